// File: rtl/xlb_stream_pkg.sv
// Shared definitions for the Xillybus <-> HLS ap_fifo stream bridge.
package xlb_stream_pkg;

   // bit positions inside err_sticky
   localparam int ERR_WR_FULL  = 0;
   localparam int ERR_RD_EMPTY = 1;

   // end-of-stream tracking: waiting for the drain condition, or EOF raised
   typedef enum logic {
      EOF_WAIT = 1'b0,
      EOF_DONE = 1'b1
   } eof_state_t;

   // number of words held by a FIFO with the given address width
   function automatic int xlb_depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/xlb_sync_fifo.sv
// Single-clock FIFO: inferred storage, registered count/full/empty, and a
// registered read port (data appears the cycle after the pop).
module xlb_sync_fifo
   import xlb_stream_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 9
) (
   input  logic          i_clk,
   input  logic          i_flush,
   input  logic          i_push,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_pop,
   output logic [DW-1:0] o_rdata,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty
);

   localparam int            DEPTH   = xlb_depth(AW);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic          r_full, r_empty;
   logic [DW-1:0] r_rdata;
   logic [AW:0]   w_cnt_nxt;
   logic          w_push, w_pop;

   // a pop on an empty FIFO is honoured only together with a push (pass-through);
   // a push on a full FIFO is honoured only together with a pop
   assign w_pop  = i_pop & (~r_empty | i_push);
   assign w_push = i_push & (~r_full | w_pop);

   // next occupancy; simultaneous push and pop leaves it unchanged
   always_comb begin
      w_cnt_nxt = r_count;
      if (w_push & ~w_pop)
         w_cnt_nxt = r_count + (AW+1)'(1);
      else if (w_pop & ~w_push)
         w_cnt_nxt = r_count - (AW+1)'(1);
   end

   // storage array, kept free of reset so it maps onto RAM
   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wptr] <= i_wdata;
   end

   // pointers, occupancy flags and the registered read port
   always_ff @(posedge i_clk) begin
      if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_rdata <= '0;
      end else begin
         r_count <= w_cnt_nxt;
         r_full  <= (w_cnt_nxt == DEPTH_C);
         r_empty <= (w_cnt_nxt == '0);
         if (w_push)
            r_wptr <= r_wptr + AW'(1);
         if (w_pop) begin
            r_rptr  <= r_rptr + AW'(1);
            r_rdata <= r_empty ? i_wdata : r_mem[r_rptr];
         end
      end
   end

   assign o_rdata = r_rdata;
   assign o_count = r_count;
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/xlb_hls_stream_bridge.sv
// Bridge between one Xillybus write/read pipe pair and one HLS ap_fifo core,
// with runtime loopback, end-of-stream generation and word counters.
module xlb_hls_stream_bridge
   import xlb_stream_pkg::*;
#(
   parameter int DW     = 32,
   parameter int AW     = 9,
   parameter int EOF_EN = 1,
   parameter int CW     = 32
) (
   input  logic          i_clk,
   input  logic          i_srst,
   input  logic          i_cfg_loopback,
   input  logic          i_core_idle,
   input  logic          i_wr_open,
   input  logic          i_wr_wren,
   input  logic [DW-1:0] i_wr_data,
   output logic          o_wr_full,
   input  logic          i_rd_open,
   input  logic          i_rd_rden,
   output logic [DW-1:0] o_rd_data,
   output logic          o_rd_empty,
   output logic          o_rd_eof,
   output logic [DW-1:0] o_hls_in_dout,
   output logic          o_hls_in_empty_n,
   input  logic          i_hls_in_read,
   input  logic [DW-1:0] i_hls_out_din,
   input  logic          i_hls_out_write,
   output logic          o_hls_out_full_n,
   output logic          o_hls_rst,
   output logic [CW-1:0] o_in_words,
   output logic [CW-1:0] o_out_words,
   output logic [1:0]    o_err_sticky
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(xlb_depth(AW));

   logic          r_hls_rst, r_loopback;
   logic          r_src_vld;
   logic [CW-1:0] r_in_words, r_out_words;
   logic          r_err_wr, r_err_rd;
   logic          r_wr_seen;
   eof_state_t    r_eof_st;

   logic          w_in_flush, w_out_flush;
   logic          w_in_push, w_in_pop, w_in_empty, w_in_full_unused;
   logic [AW:0]   w_in_cnt, w_in_occ;
   logic [DW-1:0] w_src_data;
   logic          w_out_push, w_out_pop, w_out_empty, w_out_full;
   logic [AW:0]   w_out_cnt_unused;
   logic [DW-1:0] w_out_wdata;
   logic          w_fwd, w_take, w_eof, w_eof_cond;

   assign w_in_flush  = i_srst | ~i_wr_open;
   assign w_out_flush = i_srst | ~i_rd_open;

   // the source register counts toward input capacity, so the host sees
   // DEPTH words of buffering in total
   assign w_in_occ  = w_in_cnt + {{AW{1'b0}}, r_src_vld};
   assign o_wr_full = (w_in_occ == DEPTH_C);
   assign w_in_push = i_wr_wren & ~o_wr_full;

   // once EOF is raised nothing more may enter the output FIFO
   assign w_eof  = (EOF_EN != 0) && (r_eof_st == EOF_DONE);
   assign w_fwd  = r_loopback & r_src_vld & ~w_out_full & ~w_eof;
   assign w_take = r_loopback ? w_fwd : (i_hls_in_read & r_src_vld);

   // refill the source register whenever it is empty or being drained
   assign w_in_pop = ~w_in_empty & (~r_src_vld | w_take);

   assign w_out_push  = r_loopback ? w_fwd : (i_hls_out_write & ~w_out_full & ~w_eof);
   assign w_out_wdata = r_loopback ? w_src_data : i_hls_out_din;
   assign w_out_pop   = i_rd_rden & ~w_out_empty;

   assign w_eof_cond = r_wr_seen & ~i_wr_open & w_in_empty & ~r_src_vld &
                       (i_core_idle | r_loopback) & w_out_empty;

   // host-to-core FIFO; its read register is the ap_fifo source data
   xlb_sync_fifo #(.DW(DW), .AW(AW)) u_in_fifo (
      .i_clk   (i_clk),
      .i_flush (w_in_flush),
      .i_push  (w_in_push),
      .i_wdata (i_wr_data),
      .i_pop   (w_in_pop),
      .o_rdata (w_src_data),
      .o_count (w_in_cnt),
      .o_full  (w_in_full_unused),
      .o_empty (w_in_empty)
   );

   // core(or loopback)-to-host FIFO; its read register drives rd_data
   xlb_sync_fifo #(.DW(DW), .AW(AW)) u_out_fifo (
      .i_clk   (i_clk),
      .i_flush (w_out_flush),
      .i_push  (w_out_push),
      .i_wdata (w_out_wdata),
      .i_pop   (w_out_pop),
      .o_rdata (o_rd_data),
      .o_count (w_out_cnt_unused),
      .o_full  (w_out_full),
      .o_empty (w_out_empty)
   );

   // core reset follows srst or both pipes closed; mode is latched only then
   always_ff @(posedge i_clk) begin
      r_hls_rst <= i_srst | (~i_wr_open & ~i_rd_open);
      if (r_hls_rst)
         r_loopback <= i_cfg_loopback;
   end

   // input-side state: source valid, consumed-word counter, write-overflow flag
   always_ff @(posedge i_clk) begin
      if (w_in_flush) begin
         r_src_vld  <= 1'b0;
         r_in_words <= '0;
         r_err_wr   <= 1'b0;
      end else begin
         if (w_in_pop)
            r_src_vld <= 1'b1;
         else if (w_take)
            r_src_vld <= 1'b0;
         if (w_take && (r_in_words != '1))
            r_in_words <= r_in_words + CW'(1);
         if (i_wr_wren & o_wr_full)
            r_err_wr <= 1'b1;
      end
   end

   // output-side state: delivered-word counter, underflow flag, EOF tracking
   always_ff @(posedge i_clk) begin
      if (w_out_flush) begin
         r_out_words <= '0;
         r_err_rd    <= 1'b0;
         r_wr_seen   <= 1'b0;
         r_eof_st    <= EOF_WAIT;
      end else begin
         if (w_out_pop && (r_out_words != '1))
            r_out_words <= r_out_words + CW'(1);
         if (i_rd_rden & w_out_empty)
            r_err_rd <= 1'b1;
         if (i_wr_open & w_in_push)
            r_wr_seen <= 1'b1;
         if ((EOF_EN != 0) && (r_eof_st == EOF_WAIT) && w_eof_cond)
            r_eof_st <= EOF_DONE;
      end
   end

   assign o_rd_empty       = w_out_empty;
   assign o_rd_eof         = w_eof;
   assign o_hls_in_dout    = w_src_data;
   assign o_hls_in_empty_n = r_src_vld & ~r_loopback;
   assign o_hls_out_full_n = ~w_out_full;
   assign o_hls_rst        = r_hls_rst;
   assign o_in_words       = r_in_words;
   assign o_out_words      = r_out_words;
   assign o_err_sticky[ERR_WR_FULL]  = r_err_wr;
   assign o_err_sticky[ERR_RD_EMPTY] = r_err_rd;

endmodule

// File: doc/xlb_hls_stream_bridge.md
Name: xlb_hls_stream_bridge

Overview:
- Parametrised bridge between one Xillybus write/read pipe pair and one HLS ap_fifo core (in_arr/out_arr style).
- Buffers host-to-core data in an input FIFO and presents it through a registered ap_fifo source stage. Collects core output in an output FIFO for the Xillybus read pipe.
- Adds a runtime loopback mode, end-of-stream (EOF) generation and word counters.
- Instantiated in the top level on bus_clk, once per accelerated function.

Parameters:
- DW, 32, data width of all data paths.
- AW, 9, FIFO address width; each FIFO holds DEPTH = 2^AW words.
- EOF_EN, 1, 1 enables rd_eof generation; 0 ties rd_eof to 0.
- CW, 32, width of the word counters.

Ports:
- clk  in  1  bus_clk domain; the only clock.
- srst  in  1  synchronous active-high reset.
- cfg_loopback  in  1  1 = host data bypasses the core.
- core_idle  in  1  core ap_idle.
- wr_open  in  1  Xillybus write pipe open.
- wr_wren  in  1  Xillybus write strobe.
- wr_data  in  DW  Xillybus write data.
- wr_full  out  1  input FIFO full.
- rd_open  in  1  Xillybus read pipe open.
- rd_rden  in  1  Xillybus read strobe.
- rd_data  out  DW  Xillybus read data.
- rd_empty  out  1  output FIFO empty.
- rd_eof  out  1  end of stream.
- hls_in_dout  out  DW  core input data.
- hls_in_empty_n  out  1  core input valid.
- hls_in_read  in  1  core consumes hls_in_dout.
- hls_out_din  in  DW  core output data.
- hls_out_write  in  1  core output strobe.
- hls_out_full_n  out  1  output FIFO can accept.
- hls_rst  out  1  core reset.
- in_words  out  CW  words consumed by the core, or looped back.
- out_words  out  CW  words delivered to the host.
- err_sticky  out  2  [0] write dropped while full, [1] rden while empty.

Behaviour:
- Clock and reset: one clock, clk; reset srst, synchronous, active-high.
- Flush domains:
  - in_flush = srst | !wr_open: clears the input FIFO, the source stage, in_words and err_sticky[0].
  - out_flush = srst | !rd_open: clears the output FIFO, out_words, err_sticky[1] and the EOF state.
- hls_rst is registered: 1 while srst | (!wr_open & !rd_open), so it lags by one cycle.
- Reset values:
  - wr_full=0, rd_empty=1, rd_eof=0, hls_in_empty_n=0, hls_out_full_n=1.
  - rd_data=0, hls_in_dout=0, counters=0, err_sticky=0, hls_rst=1.
- Input FIFO:
  - Synchronous, DEPTH entries, registered occupancy count; wr_full = (count == DEPTH).
  - Write with wr_wren & !wr_full.
  - wr_wren while full: the word is dropped and err_sticky[0] is set.
- Source stage (HLS mode, cfg_loopback=0):
  - One register pair {hls_in_dout, hls_in_empty_n}.
  - Load from the FIFO head when the FIFO is non-empty and (!hls_in_empty_n | hls_in_read).
  - Otherwise hls_in_read clears hls_in_empty_n.
  - Sustains one word per cycle.
  - hls_in_read while hls_in_empty_n=0 is ignored.
  - in_words increments on every hls_in_read & hls_in_empty_n.
- Loopback mode (cfg_loopback=1):
  - The source stage forwards into the output FIFO whenever that FIFO is not full.
  - hls_in_empty_n is held 0; hls_out_write is ignored.
  - in_words counts forwarded words.
- cfg_loopback is sampled only while hls_rst=1; changes at other times have no effect until the next hls_rst.
- Output FIFO:
  - Synchronous, DEPTH entries.
  - hls_out_full_n = (count < DEPTH), driven from a register only.
  - A write with hls_out_write & !hls_out_full_n is dropped.
- Xillybus read:
  - rd_empty = (count == 0).
  - rd_rden & !rd_empty pops; rd_data is valid on the cycle after rd_rden (read latency 1).
  - rd_rden while empty sets err_sticky[1] and leaves rd_data unchanged.
  - out_words increments per accepted pop.
- Simultaneous push and pop on either FIFO: count unchanged. This is legal both when full and when empty; the word goes through the FIFO normally.
- EOF (EOF_EN=1):
  - A flag wr_seen is set when wr_open=1 and at least one word has been written.
  - rd_eof rises one cycle after all of the following hold: wr_seen & !wr_open, input FIFO empty, source stage empty, core_idle=1 (or loopback), output FIFO empty.
  - rd_eof holds until out_flush.
  - rd_eof=1 implies rd_empty=1.
  - wr_open re-rising before rd_eof does not clear wr_seen; the in-flight EOF is cancelled until the next close.
- Counters saturate at 2^CW-1 and do not wrap.
- Pointers wrap modulo DEPTH.

Decomposition:
- Package xlb_stream_pkg: localparams for err_sticky bit indices, the DEPTH function of AW, and the EOF condition enum.
- One sub-module, xlb_sync_fifo (parameters DW, AW): inferred RAM, registered count, full/empty flags, read latency 1. Instantiated twice.

Test Plan:
- DW=32, AW=4: 16 host writes of 0x0..0xF, core idle (hls_in_read=0) → wr_full=1 after the 16th write (15 words in the FIFO plus 1 in the source stage); the 17th write is dropped and err_sticky=2'b01.
- HLS mode, core asserting hls_in_read every cycle and echoing data+1 → host reads 0x1..0x10 in order; in_words=out_words=16; no stall cycles after the first word.
- cfg_loopback=1 set during hls_rst, write 0xDEADBEEF and 0x12345678 → rd_data returns both in order; hls_in_empty_n never rises.
- wr_open drops after 3 words, core_idle=1, host drains the output FIFO → rd_eof=1 exactly one cycle after the last pop; rd_open=0 clears it.
- rd_rden with rd_empty=1 → err_sticky[1]=1 and rd_data unchanged; srst mid-stream (5 words buffered) → all outputs return to reset values the next cycle.
- CW=4: push 20 words through → in_words and out_words saturate at 15.
